// File: rtl/dcache_mshr_pkg.sv
// Shared types and constants for the D-cache miss-status holding registers.
package dcache_mshr_pkg;

  localparam int MSHR_NUM = 4;
  localparam int TAG_W    = 7;
  localparam int IDX_W    = 6;
  localparam int SLOT_W   = $clog2(MSHR_NUM);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    FILL    = 3'd3,
    ST_INST = 3'd4
  } mshr_state_t;

  typedef struct packed {
    mshr_state_t      state;
    logic             st;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [63:0]      data;
    logic [3:0]       mem_tag;
  } mshr_entry_t;

  // Word-aligned memory address of a cache line: {zeros, tag, idx, 3'b000}.
  function automatic logic [63:0] mem_addr(input logic [TAG_W-1:0] tag,
                                           input logic [IDX_W-1:0] idx);
    return {{(64 - TAG_W - IDX_W - 3){1'b0}}, tag, idx, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_mshr_if.sv
// Memory-bus side of the MSHR: one command per cycle, tagged responses.
interface dcache_mshr_if;
  logic [1:0]  mem_cmd_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_data_o;
  logic [3:0]  mem_rsp_i;
  logic [3:0]  mem_tag_i;
  logic [63:0] mem_data_i;

  modport master (output mem_cmd_o, mem_addr_o, mem_data_o,
                  input  mem_rsp_i, mem_tag_i, mem_data_i);
  modport slave  (input  mem_cmd_o, mem_addr_o, mem_data_o,
                  output mem_rsp_i, mem_tag_i, mem_data_i);
endinterface

// File: rtl/dcache_mshr_pe.sv
// Lowest-set-bit priority encoder: slot 0 has the highest priority.
module dcache_mshr_pe #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  // Scan from the top down so the lowest requesting slot is the last (winning) write.
  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/dcache_mshr.sv
// D-cache MSHR: tracks load/store misses, issues memory loads, writes back dirty
// victims and drives the cachemem fill / store-install ports.
module dcache_mshr
  import dcache_mshr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req_en_i,
  input  logic              miss_req_st_i,
  input  logic [TAG_W-1:0]  miss_req_tag_i,
  input  logic [IDX_W-1:0]  miss_req_idx_i,
  input  logic [63:0]       miss_req_data_i,
  output logic              miss_req_rdy_o,
  output logic              mshr_rsp_wr_en_o,
  output logic [TAG_W-1:0]  mshr_rsp_wr_tag_o,
  output logic [IDX_W-1:0]  mshr_rsp_wr_idx_o,
  output logic [63:0]       mshr_rsp_wr_data_o,
  input  logic              mshr_rsp_wr_dty_i,
  output logic              mshr_iss_st_en_o,
  output logic [TAG_W-1:0]  mshr_iss_tag_o,
  output logic [IDX_W-1:0]  mshr_iss_idx_o,
  output logic [63:0]       mshr_iss_data_o,
  input  logic              mshr_iss_dty_i,
  output logic              mshr_evict_en_o,
  output logic [IDX_W-1:0]  mshr_evict_idx_o,
  input  logic [TAG_W-1:0]  mshr_evict_tag_i,
  input  logic [63:0]       mshr_evict_data_i,
  output logic              lq_fill_vld_o,
  output logic [TAG_W-1:0]  lq_fill_tag_o,
  output logic [IDX_W-1:0]  lq_fill_idx_o,
  output logic [63:0]       lq_fill_data_o,
  dcache_mshr_if.master     mem_if
);

  mshr_entry_t entries_q [MSHR_NUM];
  mshr_entry_t entries_d [MSHR_NUM];

  logic [MSHR_NUM-1:0] free_vec, own_vec, ldreq_vec;
  logic                conflict;
  logic                alloc_vld, own_vld, ld_vld;
  logic [SLOT_W-1:0]   alloc_idx, own_idx, ld_idx;
  mshr_entry_t         owner, ld_ent;
  logic                owner_dty;

  // Per-slot status vectors and the same-set conflict check against occupied slots.
  always_comb begin
    free_vec  = '0;
    own_vec   = '0;
    ldreq_vec = '0;
    conflict  = 1'b0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      free_vec[i]  = (entries_q[i].state == IDLE);
      own_vec[i]   = (entries_q[i].state == FILL) || (entries_q[i].state == ST_INST);
      ldreq_vec[i] = (entries_q[i].state == LD_REQ);
      if (entries_q[i].state != IDLE && entries_q[i].idx == miss_req_idx_i) conflict = 1'b1;
    end
  end

  dcache_mshr_pe #(.N(MSHR_NUM)) u_pe_alloc (.req_i(free_vec),  .vld_o(alloc_vld), .idx_o(alloc_idx));
  dcache_mshr_pe #(.N(MSHR_NUM)) u_pe_owner (.req_i(own_vec),   .vld_o(own_vld),   .idx_o(own_idx));
  dcache_mshr_pe #(.N(MSHR_NUM)) u_pe_load  (.req_i(ldreq_vec), .vld_o(ld_vld),    .idx_o(ld_idx));

  assign miss_req_rdy_o = alloc_vld && !conflict;
  assign owner          = entries_q[own_idx];
  assign ld_ent         = entries_q[ld_idx];
  // A store owner looks at the iss-port dirty bit, a fill owner at the rsp-port one.
  assign owner_dty      = own_vld && (owner.st ? mshr_iss_dty_i : mshr_rsp_wr_dty_i);

  // Output decode and next-state for the whole entry array.
  always_comb begin
    // NOTE: every output and the next-state array get a default first, so no path can infer a latch.
    entries_d          = entries_q;
    mshr_rsp_wr_en_o   = 1'b0;
    mshr_rsp_wr_tag_o  = '0;
    mshr_rsp_wr_idx_o  = '0;
    mshr_rsp_wr_data_o = '0;
    mshr_iss_st_en_o   = 1'b0;
    mshr_iss_tag_o     = '0;
    mshr_iss_idx_o     = '0;
    mshr_iss_data_o    = '0;
    mshr_evict_en_o    = 1'b0;
    mshr_evict_idx_o   = '0;
    lq_fill_vld_o      = 1'b0;
    lq_fill_tag_o      = '0;
    lq_fill_idx_o      = '0;
    lq_fill_data_o     = '0;
    mem_if.mem_cmd_o   = BUS_NONE;
    mem_if.mem_addr_o  = '0;
    mem_if.mem_data_o  = '0;

    // Cache port owner: write back a dirty victim first, otherwise fill or install.
    if (own_vld) begin
      mshr_rsp_wr_tag_o  = owner.tag;
      mshr_rsp_wr_idx_o  = owner.idx;
      mshr_rsp_wr_data_o = owner.data;
      mshr_iss_tag_o     = owner.tag;
      mshr_iss_idx_o     = owner.idx;
      mshr_iss_data_o    = owner.data;
      if (owner_dty) begin
        mem_if.mem_cmd_o  = BUS_STORE;
        mem_if.mem_addr_o = mem_addr(mshr_evict_tag_i, owner.idx);
        mem_if.mem_data_o = mshr_evict_data_i;
        if (mem_if.mem_rsp_i != 4'd0) begin
          mshr_evict_en_o  = 1'b1;
          mshr_evict_idx_o = owner.idx;
        end
      end else if (!owner.st) begin
        mshr_rsp_wr_en_o           = 1'b1;
        lq_fill_vld_o              = 1'b1;
        lq_fill_tag_o              = owner.tag;
        lq_fill_idx_o              = owner.idx;
        lq_fill_data_o             = owner.data;
        entries_d[own_idx].state   = IDLE;
      end else begin
        mshr_iss_st_en_o           = 1'b1;
        entries_d[own_idx].state   = IDLE;
      end
    end

    // Load issue uses the bus only when no write-back claims it.
    if (!owner_dty && ld_vld) begin
      mem_if.mem_cmd_o  = BUS_LOAD;
      mem_if.mem_addr_o = mem_addr(ld_ent.tag, ld_ent.idx);
      if (mem_if.mem_rsp_i != 4'd0) begin
        entries_d[ld_idx].state   = LD_WAIT;
        entries_d[ld_idx].mem_tag = mem_if.mem_rsp_i;
      end
    end

    // Tag match completes a waiting load; tags are unique among LD_WAIT entries.
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (entries_q[i].state == LD_WAIT && mem_if.mem_tag_i != 4'd0 &&
          mem_if.mem_tag_i == entries_q[i].mem_tag) begin
        entries_d[i].state = FILL;
        entries_d[i].data  = mem_if.mem_data_i;
      end
    end

    // Allocation into the lowest free slot.
    if (miss_req_en_i && miss_req_rdy_o) begin
      entries_d[alloc_idx].state   = miss_req_st_i ? ST_INST : LD_REQ;
      entries_d[alloc_idx].st      = miss_req_st_i;
      entries_d[alloc_idx].tag     = miss_req_tag_i;
      entries_d[alloc_idx].idx     = miss_req_idx_i;
      entries_d[alloc_idx].data    = miss_req_st_i ? miss_req_data_i : 64'd0;
      entries_d[alloc_idx].mem_tag = 4'd0;
    end
  end

  // Entry array register with synchronous reset that drops every entry.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is a handful of flops, so it is reset whole; only state strictly needs it.
    if (rst) begin
      for (int i = 0; i < MSHR_NUM; i++) entries_q[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so all entries advance together at the edge.
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed self-checking bench for dcache_mshr.
module tb_dcache_mshr;
  import dcache_mshr_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_req_en_i, miss_req_st_i;
  logic [TAG_W-1:0]  miss_req_tag_i;
  logic [IDX_W-1:0]  miss_req_idx_i;
  logic [63:0]       miss_req_data_i;
  logic              miss_req_rdy_o;
  logic              mshr_rsp_wr_en_o;
  logic [TAG_W-1:0]  mshr_rsp_wr_tag_o;
  logic [IDX_W-1:0]  mshr_rsp_wr_idx_o;
  logic [63:0]       mshr_rsp_wr_data_o;
  logic              mshr_rsp_wr_dty_i;
  logic              mshr_iss_st_en_o;
  logic [TAG_W-1:0]  mshr_iss_tag_o;
  logic [IDX_W-1:0]  mshr_iss_idx_o;
  logic [63:0]       mshr_iss_data_o;
  logic              mshr_iss_dty_i;
  logic              mshr_evict_en_o;
  logic [IDX_W-1:0]  mshr_evict_idx_o;
  logic [TAG_W-1:0]  mshr_evict_tag_i;
  logic [63:0]       mshr_evict_data_i;
  logic              lq_fill_vld_o;
  logic [TAG_W-1:0]  lq_fill_tag_o;
  logic [IDX_W-1:0]  lq_fill_idx_o;
  logic [63:0]       lq_fill_data_o;

  dcache_mshr_if mem_if ();

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_mshr dut (
    .clk                (clk),
    .rst                (rst),
    .miss_req_en_i      (miss_req_en_i),
    .miss_req_st_i      (miss_req_st_i),
    .miss_req_tag_i     (miss_req_tag_i),
    .miss_req_idx_i     (miss_req_idx_i),
    .miss_req_data_i    (miss_req_data_i),
    .miss_req_rdy_o     (miss_req_rdy_o),
    .mshr_rsp_wr_en_o   (mshr_rsp_wr_en_o),
    .mshr_rsp_wr_tag_o  (mshr_rsp_wr_tag_o),
    .mshr_rsp_wr_idx_o  (mshr_rsp_wr_idx_o),
    .mshr_rsp_wr_data_o (mshr_rsp_wr_data_o),
    .mshr_rsp_wr_dty_i  (mshr_rsp_wr_dty_i),
    .mshr_iss_st_en_o   (mshr_iss_st_en_o),
    .mshr_iss_tag_o     (mshr_iss_tag_o),
    .mshr_iss_idx_o     (mshr_iss_idx_o),
    .mshr_iss_data_o    (mshr_iss_data_o),
    .mshr_iss_dty_i     (mshr_iss_dty_i),
    .mshr_evict_en_o    (mshr_evict_en_o),
    .mshr_evict_idx_o   (mshr_evict_idx_o),
    .mshr_evict_tag_i   (mshr_evict_tag_i),
    .mshr_evict_data_i  (mshr_evict_data_i),
    .lq_fill_vld_o      (lq_fill_vld_o),
    .lq_fill_tag_o      (lq_fill_tag_o),
    .lq_fill_idx_o      (lq_fill_idx_o),
    .lq_fill_data_o     (lq_fill_data_o),
    .mem_if             (mem_if.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the active edge; inputs are then driven for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point for the current cycle, half a period away from the active edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, ".mem_cmd"},   64'(mem_if.mem_cmd_o),  64'(BUS_NONE));
    check({pfx, ".mem_addr"},  mem_if.mem_addr_o,      64'd0);
    check({pfx, ".rsp_wr_en"}, 64'(mshr_rsp_wr_en_o), 64'd0);
    check({pfx, ".iss_st_en"}, 64'(mshr_iss_st_en_o), 64'd0);
    check({pfx, ".evict_en"},  64'(mshr_evict_en_o),  64'd0);
    check({pfx, ".lq_vld"},    64'(lq_fill_vld_o),    64'd0);
  endtask

  // Line addresses {tag, idx, 3'b000} for tags 0x20..0x23 at sets 0x10..0x13.
  logic [63:0] fill_addr [4] = '{64'h4080, 64'h4288, 64'h4490, 64'h4698};

  initial begin
    rst = 1'b1;
    miss_req_en_i = 1'b0; miss_req_st_i = 1'b0; miss_req_tag_i = '0; miss_req_idx_i = '0;
    miss_req_data_i = '0; mshr_rsp_wr_dty_i = 1'b0; mshr_iss_dty_i = 1'b0;
    mshr_evict_tag_i = '0; mshr_evict_data_i = '0;
    mem_if.mem_rsp_i = '0; mem_if.mem_tag_i = '0; mem_if.mem_data_i = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. Reset state
    settle();
    check_quiet("reset");
    check("reset.mem_data", mem_if.mem_data_o, 64'd0);
    check("reset.rsp_wr_idx", 64'(mshr_rsp_wr_idx_o), 64'd0);
    check("reset.rdy", 64'(miss_req_rdy_o), 64'd1);
    tick();

    // 2. Uncontended load miss with a clean victim
    miss_req_en_i = 1'b1; miss_req_st_i = 1'b0; miss_req_tag_i = 7'h05; miss_req_idx_i = 6'h03;
    settle();
    check("ld.rdy", 64'(miss_req_rdy_o), 64'd1);
    tick();
    miss_req_en_i = 1'b0;
    mem_if.mem_rsp_i = 4'd1;
    settle();
    check("ld.cmd", 64'(mem_if.mem_cmd_o), 64'(BUS_LOAD));
    check("ld.addr", mem_if.mem_addr_o, 64'h0A18);
    tick();
    mem_if.mem_rsp_i = 4'd0;
    settle();
    check("ld.wait_cmd", 64'(mem_if.mem_cmd_o), 64'(BUS_NONE));
    tick();
    mem_if.mem_tag_i = 4'd1; mem_if.mem_data_i = 64'hDEAD;
    settle();
    check("ld.no_early_fill", 64'(mshr_rsp_wr_en_o), 64'd0);
    tick();
    mem_if.mem_tag_i = 4'd0; mem_if.mem_data_i = 64'd0;
    settle();
    check("ld.fill_en", 64'(mshr_rsp_wr_en_o), 64'd1);
    check("ld.fill_data", mshr_rsp_wr_data_o, 64'hDEAD);
    check("ld.fill_idx", 64'(mshr_rsp_wr_idx_o), 64'h03);
    check("ld.fill_tag", 64'(mshr_rsp_wr_tag_o), 64'h05);
    check("ld.lq_vld", 64'(lq_fill_vld_o), 64'd1);
    check("ld.lq_data", lq_fill_data_o, 64'hDEAD);
    check("ld.lq_idx", 64'(lq_fill_idx_o), 64'h03);
    tick();
    settle();
    check("ld.fill_pulse", 64'(mshr_rsp_wr_en_o), 64'd0);
    check("ld.lq_pulse", 64'(lq_fill_vld_o), 64'd0);
    tick();

    // 3. Store miss with a dirty victim: write-back, then install
    miss_req_en_i = 1'b1; miss_req_st_i = 1'b1; miss_req_tag_i = 7'h22; miss_req_idx_i = 6'h0A;
    miss_req_data_i = 64'h1234;
    tick();
    miss_req_en_i = 1'b0; miss_req_st_i = 1'b0;
    mshr_iss_dty_i = 1'b1; mshr_evict_tag_i = 7'h11; mshr_evict_data_i = 64'hBEEF;
    settle();
    check("st.wb_cmd", 64'(mem_if.mem_cmd_o), 64'(BUS_STORE));
    check("st.wb_addr", mem_if.mem_addr_o, 64'h2250);
    check("st.wb_data", mem_if.mem_data_o, 64'hBEEF);
    check("st.evict_wait", 64'(mshr_evict_en_o), 64'd0);
    check("st.no_install", 64'(mshr_iss_st_en_o), 64'd0);
    tick();
    mem_if.mem_rsp_i = 4'd3;
    settle();
    check("st.wb_cmd2", 64'(mem_if.mem_cmd_o), 64'(BUS_STORE));
    check("st.evict_en", 64'(mshr_evict_en_o), 64'd1);
    check("st.evict_idx", 64'(mshr_evict_idx_o), 64'h0A);
    check("st.no_install2", 64'(mshr_iss_st_en_o), 64'd0);
    tick();
    mem_if.mem_rsp_i = 4'd0; mshr_iss_dty_i = 1'b0;
    settle();
    check("st.install", 64'(mshr_iss_st_en_o), 64'd1);
    check("st.iss_idx", 64'(mshr_iss_idx_o), 64'h0A);
    check("st.iss_tag", 64'(mshr_iss_tag_o), 64'h22);
    check("st.iss_data", mshr_iss_data_o, 64'h1234);
    check("st.cmd_idle", 64'(mem_if.mem_cmd_o), 64'(BUS_NONE));
    check("st.no_fill", 64'(mshr_rsp_wr_en_o), 64'd0);
    tick();
    settle();
    check("st.install_pulse", 64'(mshr_iss_st_en_o), 64'd0);
    tick();

    // 4. Rejected load retries with identical outputs
    miss_req_en_i = 1'b1; miss_req_tag_i = 7'h01; miss_req_idx_i = 6'h05;
    tick();
    miss_req_en_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      settle();
      check($sformatf("rej.cmd%0d", r), 64'(mem_if.mem_cmd_o), 64'(BUS_LOAD));
      check($sformatf("rej.addr%0d", r), mem_if.mem_addr_o, 64'h0228);
      tick();
    end
    mem_if.mem_rsp_i = 4'd2;
    settle();
    check("rej.accept_cmd", 64'(mem_if.mem_cmd_o), 64'(BUS_LOAD));
    tick();
    mem_if.mem_rsp_i = 4'd0;
    settle();
    check("rej.advanced", 64'(mem_if.mem_cmd_o), 64'(BUS_NONE));
    tick();
    mem_if.mem_tag_i = 4'd2; mem_if.mem_data_i = 64'h55;
    tick();
    mem_if.mem_tag_i = 4'd0;
    settle();
    check("rej.fill_idx", 64'(lq_fill_idx_o), 64'h05);
    check("rej.fill_data", lq_fill_data_o, 64'h55);
    tick();

    // 5. Fill all slots, full/conflict back-pressure, out-of-order returns
    for (int k = 0; k < 4; k++) begin
      miss_req_en_i = 1'b1; miss_req_tag_i = 7'(7'h20 + k); miss_req_idx_i = 6'(6'h10 + k);
      if (k == 1) begin
        miss_req_idx_i = 6'h10;
        #1;
        check("full.conflict_rdy", 64'(miss_req_rdy_o), 64'd0);
        miss_req_idx_i = 6'h11;
      end
      settle();
      check($sformatf("full.rdy%0d", k), 64'(miss_req_rdy_o), 64'd1);
      tick();
    end
    miss_req_tag_i = 7'h24; miss_req_idx_i = 6'h14;
    settle();
    check("full.rdy_none_free", 64'(miss_req_rdy_o), 64'd0);
    tick();
    miss_req_en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_if.mem_rsp_i = 4'(k + 1);
      settle();
      check($sformatf("full.ld_cmd%0d", k), 64'(mem_if.mem_cmd_o), 64'(BUS_LOAD));
      check($sformatf("full.ld_addr%0d", k), mem_if.mem_addr_o, fill_addr[k]);
      tick();
    end
    mem_if.mem_rsp_i = 4'd0;
    mem_if.mem_tag_i = 4'd3; mem_if.mem_data_i = 64'h333;
    settle();
    check("ooo.no_fill_yet", 64'(mshr_rsp_wr_en_o), 64'd0);
    tick();
    mem_if.mem_tag_i = 4'd2; mem_if.mem_data_i = 64'h222;
    settle();
    check("ooo.fill3_en", 64'(mshr_rsp_wr_en_o), 64'd1);
    check("ooo.fill3_idx", 64'(mshr_rsp_wr_idx_o), 64'h12);
    check("ooo.fill3_tag", 64'(lq_fill_tag_o), 64'h22);
    check("ooo.fill3_data", lq_fill_data_o, 64'h333);
    tick();
    mem_if.mem_tag_i = 4'd0; mem_if.mem_data_i = 64'd0;
    settle();
    check("ooo.fill2_idx", 64'(lq_fill_idx_o), 64'h11);
    check("ooo.fill2_data", mshr_rsp_wr_data_o, 64'h222);
    tick();
    settle();
    check("ooo.quiet", 64'(lq_fill_vld_o), 64'd0);

    // 6. Reset with two entries in LD_WAIT (mem tags 1 and 4)
    rst = 1'b1;
    tick();
    settle();
    check_quiet("rst_mid");
    check("rst_mid.rdy", 64'(miss_req_rdy_o), 64'd1);
    tick();
    rst = 1'b0;
    mem_if.mem_tag_i = 4'd1; mem_if.mem_data_i = 64'h999;
    tick();
    mem_if.mem_tag_i = 4'd0; mem_if.mem_data_i = 64'd0;
    settle();
    check_quiet("rst_stale");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
